// File: rtl/btb_pkg.sv
// Shared types and helpers for the BTB tag store: FSM state, WAYS legality,
// way-index width and tree pseudo-LRU victim/touch functions (2 or 4 ways).
package btb_pkg;

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   function automatic bit ways_legal(input int ways);
      return (ways == 2) || (ways == 4);
   endfunction

   function automatic int way_w(input int ways);
      return (ways == 4) ? 2 : 1;
   endfunction

   // Bit 0 is the root; a 0 bit points the victim left, a 1 bit points it right.
   function automatic logic [1:0] plru_victim(input logic [2:0] bits, input int ways);
      if (ways == 2) return {1'b0, bits[0]};
      return bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
   endfunction

   function automatic logic [2:0] plru_touch(input logic [2:0] bits, input logic [1:0] way,
                                             input int ways);
      logic [2:0] r;
      r = bits;
      if (ways == 2) begin
         r[0] = ~way[0];
      end else begin
         r[0] = ~way[1];
         if (way[1]) r[2] = ~way[0];
         else        r[1] = ~way[0];
      end
      return r;
   endfunction

endpackage

// File: rtl/btb_tag_array_if.sv
// Lookup/install/response bundle of the BTB tag store; master is the fetch side.
interface btb_tag_array_if #(
   parameter int SET_W = 6,
   parameter int TAG_W = 20,
   parameter int WAYS  = 4
);
   localparam int WW = btb_pkg::way_w(WAYS);

   logic             ready;
   logic             lk_valid;
   logic [SET_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             rsp_valid;
   logic             rsp_hit;
   logic [WW-1:0]    rsp_way;
   logic             up_en;
   logic [SET_W-1:0] up_idx;
   logic [TAG_W-1:0] up_tag;
   logic             parity_err;

   modport master (
      output lk_valid, lk_idx, lk_tag, up_en, up_idx, up_tag,
      input  ready, rsp_valid, rsp_hit, rsp_way, parity_err
   );

   modport slave (
      input  lk_valid, lk_idx, lk_tag, up_en, up_idx, up_tag,
      output ready, rsp_valid, rsp_hit, rsp_way, parity_err
   );
endinterface

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: victim select and MRU-touch update of WAYS-1 bits.
module plru_tree
   import btb_pkg::*;
#(
   parameter  int WAYS = 4,
   localparam int WW   = way_w(WAYS)
) (
   input  logic [WAYS-2:0] i_bits,
   input  logic [WW-1:0]   i_way,
   output logic [WW-1:0]   o_victim,
   output logic [WAYS-2:0] o_bits
);
   logic [2:0] w_bits;
   logic [2:0] w_touch;
   logic [1:0] w_victim;

   assign w_bits   = 3'(i_bits);
   assign w_victim = plru_victim(w_bits, WAYS);
   assign w_touch  = plru_touch(w_bits, 2'(i_way), WAYS);
   assign o_victim = w_victim[WW-1:0];
   assign o_bits   = w_touch[WAYS-2:0];
endmodule

// File: rtl/btb_tag_array.sv
// Set-associative BTB tag store: sweep-cleared valid/PLRU, 1-cycle lookup, victim install.
// Define BTB_TAG_PARITY_EN for per-way even parity with invalidate-on-error.
module btb_tag_array
   import btb_pkg::*;
#(
   parameter int SET_W = 6,
   parameter int TAG_W = 20,
   parameter int WAYS  = 4
) (
   input logic            i_clk,
   input logic            i_reset,
   input logic            i_flush,
   btb_tag_array_if.slave bus
);
   localparam int SETS = 1 << SET_W;
   localparam int WW   = way_w(WAYS);

   generate
      if (!ways_legal(WAYS)) begin : g_bad_ways
         $error("btb_tag_array: WAYS must be 2 or 4");
      end
   endgenerate

   function automatic logic [WW-1:0] lowest(input logic [WAYS-1:0] v);
      logic [WW-1:0] r;
      r = '0;
      for (int i = WAYS - 1; i >= 0; i--)
         if (v[i]) r = WW'(i);
      return r;
   endfunction

   // Separate arrays so the sweep touches only valid/PLRU state.
   logic [TAG_W-1:0] r_tag   [SETS][WAYS];
   logic [WAYS-1:0]  r_valid [SETS];
   logic [WAYS-2:0]  r_plru  [SETS];
`ifdef BTB_TAG_PARITY_EN
   logic [WAYS-1:0]  r_par   [SETS];
   logic             r_perr;
`endif

   state_e           r_state, w_state_nxt;
   logic [SET_W-1:0] r_sweep;
   logic             w_ready, w_go, w_lk, w_up;
   logic             r_rsp_valid, r_rsp_hit;
   logic [WW-1:0]    r_rsp_way;

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= ST_INIT;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (i_flush) w_state_nxt = ST_INIT;
      else begin
         case (r_state)
            ST_INIT: if (&r_sweep) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
         endcase
      end
   end

   always_comb begin
      w_ready = (r_state == ST_RUN);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush || r_state != ST_INIT) r_sweep <= '0;
      else                                          r_sweep <= r_sweep + SET_W'(1);
   end

   assign w_go = w_ready & ~i_reset & ~i_flush;
   assign w_lk = w_go & bus.lk_valid;
   assign w_up = w_go & bus.up_en;

   logic [WAYS-1:0] w_lk_vld, w_lk_bad, w_lk_match;
   logic [WAYS-2:0] w_lk_plru, w_lk_plru_nxt;
   logic [WW-1:0]   w_lk_way, w_lk_vic;
   logic            w_lk_hit;

   assign w_lk_vld  = r_valid[bus.lk_idx];
   assign w_lk_plru = r_plru[bus.lk_idx];

   always_comb begin
      w_lk_bad   = '0;
      w_lk_match = '0;
      for (int w = 0; w < WAYS; w++) begin
`ifdef BTB_TAG_PARITY_EN
         w_lk_bad[w] = w_lk_vld[w] & (^{r_par[bus.lk_idx][w], r_tag[bus.lk_idx][w]});
`endif
         w_lk_match[w] = w_lk_vld[w] & ~w_lk_bad[w] & (r_tag[bus.lk_idx][w] == bus.lk_tag);
      end
   end

   assign w_lk_hit = |w_lk_match;
   assign w_lk_way = w_lk_hit    ? lowest(w_lk_match) :
                     |w_lk_bad   ? lowest(w_lk_bad)   :
                     ~&w_lk_vld  ? lowest(~w_lk_vld)  : w_lk_vic;

   plru_tree #(.WAYS(WAYS)) u_plru_lk (
      .i_bits(w_lk_plru), .i_way(w_lk_way), .o_victim(w_lk_vic), .o_bits(w_lk_plru_nxt)
   );

   logic [WAYS-1:0] w_up_vld, w_up_match;
   logic [WAYS-2:0] w_up_plru, w_up_plru_nxt;
   logic [WW-1:0]   w_up_way, w_up_vic;

   assign w_up_vld  = r_valid[bus.up_idx];
   assign w_up_plru = r_plru[bus.up_idx];

   always_comb begin
      w_up_match = '0;
      for (int w = 0; w < WAYS; w++)
         w_up_match[w] = w_up_vld[w] & (r_tag[bus.up_idx][w] == bus.up_tag);
   end

   assign w_up_way = |w_up_match ? lowest(w_up_match) :
                     ~&w_up_vld  ? lowest(~w_up_vld)  : w_up_vic;

   plru_tree #(.WAYS(WAYS)) u_plru_up (
      .i_bits(w_up_plru), .i_way(w_up_way), .o_victim(w_up_vic), .o_bits(w_up_plru_nxt)
   );

   // Install writes come last so a same-set install overrides the lookup's touch.
   always_ff @(posedge i_clk) begin
      if (r_state == ST_INIT) begin
         r_valid[r_sweep] <= '0;
         r_plru[r_sweep]  <= '0;
      end else begin
         if (w_lk && w_lk_hit) r_plru[bus.lk_idx] <= w_lk_plru_nxt;
`ifdef BTB_TAG_PARITY_EN
         if (w_lk && |w_lk_bad) r_valid[bus.lk_idx] <= w_lk_vld & ~w_lk_bad;
`endif
         if (w_up) begin
            r_tag[bus.up_idx][w_up_way]   <= bus.up_tag;
            r_valid[bus.up_idx][w_up_way] <= 1'b1;
            r_plru[bus.up_idx]            <= w_up_plru_nxt;
`ifdef BTB_TAG_PARITY_EN
            r_par[bus.up_idx][w_up_way]   <= ^bus.up_tag;
`endif
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rsp_valid <= 1'b0;
         r_rsp_hit   <= 1'b0;
         r_rsp_way   <= '0;
`ifdef BTB_TAG_PARITY_EN
         r_perr      <= 1'b0;
`endif
      end else begin
         r_rsp_valid <= w_lk;
`ifdef BTB_TAG_PARITY_EN
         r_perr      <= w_lk & (|w_lk_bad);
`endif
         if (w_lk) begin
            r_rsp_hit <= w_lk_hit;
            r_rsp_way <= w_lk_way;
         end
      end
   end

   assign bus.ready     = w_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_hit   = r_rsp_hit;
   assign bus.rsp_way   = r_rsp_way;
`ifdef BTB_TAG_PARITY_EN
   assign bus.parity_err = r_perr;
`else
   assign bus.parity_err = 1'b0;
`endif
endmodule
